// File: rtl/adc_pkg.sv
// Shared types, constants and config-word helper for the LTC2308 SPI controller.
package adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CONVST,
        CONV,
        SHIFT,
        DONE
    } adc_state_t;

    localparam int unsigned CONVST_CYCLES = 2;
    localparam int unsigned ADC_BITS      = 12;
    localparam int unsigned CFG_BITS      = 6;

    // {S/D, O/S, S1, S0, UNI, SLP}: single-ended, unipolar, no sleep
    function automatic logic [5:0] adc_cfg(input logic [2:0] chan);
        return {1'b1, chan[0], chan[2], chan[1], 1'b1, 1'b0};
    endfunction

endpackage

// File: rtl/adc_ltc2308_ctrl.sv
// Free-running LTC2308 SPI master: starts conversions, reads the previous result
// and shifts in the channel configuration for the next conversion.
module adc_ltc2308_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned SCK_HALF    = 2,
    parameter int unsigned CONV_CYCLES = 80
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [2:0]          chan,
    input  logic                adc_sdo,
    output logic                adc_convst,
    output logic                adc_sck,
    output logic                adc_sdi,
    output logic [ADC_BITS-1:0] result,
    output logic [2:0]          result_chan,
    output logic                result_valid
);

    localparam int unsigned CNT_MAX = (CONV_CYCLES > SCK_HALF) ? CONV_CYCLES : SCK_HALF;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned BIT_W   = 4;

    localparam logic [CNT_W-1:0] CONVST_LOAD = CNT_W'(CONVST_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LOAD   = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD   = CNT_W'(SCK_HALF - 1);
    localparam logic [BIT_W-1:0] LAST_BIT    = BIT_W'(ADC_BITS - 1);

    adc_state_t          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic                phase_q, phase_d;     // 0: SCK low phase, 1: SCK high phase
    logic [ADC_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]          cfg_chan_q, cfg_chan_d;
    logic [2:0]          prev_chan_q, prev_chan_d;
    logic                first_q, first_d;
    logic                sdo_q;

    logic                convst_q, convst_d;
    logic                sck_q, sck_d;
    logic                sdi_q, sdi_d;
    logic                valid_q, valid_d;
    logic [ADC_BITS-1:0] result_q, result_d;
    logic [2:0]          result_chan_q, result_chan_d;
    logic [5:0]          cfg_word;
    logic [2:0]          cfg_idx;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            phase_q     <= 1'b0;
            shreg_q     <= '0;
            cfg_chan_q  <= '0;
            prev_chan_q <= '0;
            first_q     <= 1'b1;
            sdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            phase_q     <= phase_d;
            shreg_q     <= shreg_d;
            cfg_chan_q  <= cfg_chan_d;
            prev_chan_q <= prev_chan_d;
            first_q     <= first_d;
            sdo_q       <= adc_sdo;
        end
    end

    // Next-state: one shared down-counter times every state and SCK phase
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        phase_d     = phase_q;
        shreg_d     = shreg_q;
        cfg_chan_d  = cfg_chan_q;
        prev_chan_d = prev_chan_q;
        first_d     = first_q;
        case (state_q)
            IDLE: begin
                state_d    = CONVST;
                cnt_d      = CONVST_LOAD;
                cfg_chan_d = chan;
            end
            CONVST: begin
                if (cnt_q == '0) begin
                    state_d = CONV;
                    cnt_d   = CONV_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            CONV: begin
                if (cnt_q == '0) begin
                    state_d = SHIFT;
                    cnt_d   = HALF_LOAD;
                    phase_d = 1'b0;
                    bit_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SHIFT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (!phase_q) begin
                    shreg_d = {shreg_q[ADC_BITS-2:0], sdo_q};
                    phase_d = 1'b1;
                    cnt_d   = HALF_LOAD;
                end else begin
                    phase_d = 1'b0;
                    cnt_d   = HALF_LOAD;
                    if (bit_q == LAST_BIT) begin
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            DONE: begin
                state_d     = CONVST;
                cnt_d       = CONVST_LOAD;
                cfg_chan_d  = chan;
                prev_chan_d = cfg_chan_q;
                first_d     = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: pins decoded from the next state so they line up with state_q
    always_comb begin
        cfg_word      = adc_cfg(cfg_chan_q);
        cfg_idx       = 3'(CFG_BITS - 1) - bit_d[2:0];
        convst_d      = (state_d == CONVST);
        sck_d         = (state_d == SHIFT) && phase_d;
        sdi_d         = 1'b0;
        valid_d       = 1'b0;
        result_d      = result_q;
        result_chan_d = result_chan_q;
        if (state_d == SHIFT && bit_d < BIT_W'(CFG_BITS)) begin
            sdi_d = cfg_word[cfg_idx];
        end
        // The first frame after reset carries an unknown configuration
        if (state_q == DONE && !first_q) begin
            valid_d       = 1'b1;
            result_d      = shreg_q;
            result_chan_d = prev_chan_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            convst_q      <= 1'b0;
            sck_q         <= 1'b0;
            sdi_q         <= 1'b0;
            valid_q       <= 1'b0;
            result_q      <= '0;
            result_chan_q <= '0;
        end else begin
            convst_q      <= convst_d;
            sck_q         <= sck_d;
            sdi_q         <= sdi_d;
            valid_q       <= valid_d;
            result_q      <= result_d;
            result_chan_q <= result_chan_d;
        end
    end

    assign adc_convst   = convst_q;
    assign adc_sck      = sck_q;
    assign adc_sdi      = sdi_q;
    assign result       = result_q;
    assign result_chan  = result_chan_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_adc_ltc2308_ctrl.sv
// Directed bench for adc_ltc2308_ctrl with a behavioural LTC2308 model and a
// waveform monitor on a second instance built with SCK_HALF=3, CONV_CYCLES=10.
module tb_adc_ltc2308_ctrl;

    logic        clk     = 1'b0;
    logic        reset   = 1'b1;
    logic [2:0]  chan    = 3'd0;
    logic        adc_sdo = 1'b0;
    logic        adc_convst, adc_sck, adc_sdi, result_valid;
    logic [11:0] result;
    logic [2:0]  result_chan;

    logic        w_sdo = 1'b0;
    logic        w_convst, w_sck, w_sdi, w_valid;
    logic [11:0] w_result;
    logic [2:0]  w_result_chan;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #10 clk = ~clk;

    adc_ltc2308_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .chan         (chan),
        .adc_sdo      (adc_sdo),
        .adc_convst   (adc_convst),
        .adc_sck      (adc_sck),
        .adc_sdi      (adc_sdi),
        .result       (result),
        .result_chan  (result_chan),
        .result_valid (result_valid)
    );

    adc_ltc2308_ctrl #(.SCK_HALF(3), .CONV_CYCLES(10)) dut_w (
        .clk          (clk),
        .reset        (reset),
        .chan         (chan),
        .adc_sdo      (w_sdo),
        .adc_convst   (w_convst),
        .adc_sck      (w_sck),
        .adc_sdi      (w_sdi),
        .result       (w_result),
        .result_chan  (w_result_chan),
        .result_valid (w_valid)
    );

    // Edge count since the last edge that sampled reset high
    always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

    // ADC model: mode 0 returns const_word, mode 1 returns 0x100 + previously configured channel
    int          mode       = 0;
    logic [11:0] const_word = 12'hA5C;
    logic [11:0] word       = '0;
    logic [5:0]  cfg_rx     = '0;
    logic [5:0]  frame_cfg  = '0;
    int          rx_n       = 0;
    int          sdo_idx    = 0;

    always @(posedge adc_convst or posedge adc_sck or negedge adc_sck) begin
        if (adc_convst) begin
            frame_cfg = cfg_rx;
            word      = (mode == 0) ? const_word
                                    : 12'h100 + {9'd0, cfg_rx[3], cfg_rx[2], cfg_rx[4]};
            rx_n      = 0;
            sdo_idx   = 0;
            adc_sdo   = word[11];
        end else if (adc_sck) begin
            if (rx_n < 6) begin
                cfg_rx = {cfg_rx[4:0], adc_sdi};
                rx_n++;
            end
        end else begin
            #2;
            sdo_idx++;
            adc_sdo = (sdo_idx < 12) ? word[11 - sdo_idx] : 1'b0;
        end
    end

    // Waveform monitor for the SCK_HALF=3 / CONV_CYCLES=10 instance (frame = 85 cycles)
    int   w_frames = 0, w_bad_rises = 0, w_bad_len = 0, w_bad_phase = 0;
    int   w_bad_convst = 0, w_overlap = 0;
    int   w_t = 0, rises = 0, hi_run = 0, lo_run = 0, cv_run = 0;
    logic p_convst = 1'b0, p_sck = 1'b0, p_sdi = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            w_frames = 0; w_t = 0; rises = 0; hi_run = 0; lo_run = 0; cv_run = 0;
            p_convst = 1'b0; p_sck = 1'b0; p_sdi = 1'b0;
        end else begin
            if (w_convst && !p_convst) begin
                if (w_frames > 0) begin
                    if (rises != 12) w_bad_rises++;
                    if (w_t + 1 != 85) w_bad_len++;
                end
                w_frames++;
                w_t   = 0;
                rises = 0;
            end else begin
                w_t++;
            end
            if (w_convst) cv_run++;
            else if (p_convst) begin
                if (cv_run != 2) w_bad_convst++;
                cv_run = 0;
            end
            if (w_sck && (w_convst || w_t < 12)) w_overlap++;
            if (w_sck && p_sck && w_sdi != p_sdi) w_bad_phase++;
            if (w_sck && !p_sck) begin
                rises++;
                if (rises == 1 && w_t != 15) w_bad_phase++;
                if (rises > 1 && lo_run != 3) w_bad_phase++;
                hi_run = 0;
            end
            if (!w_sck && p_sck) begin
                if (hi_run != 3) w_bad_phase++;
                lo_run = 0;
            end
            if (w_sck) hi_run++;
            else lo_run++;
            p_convst = w_convst;
            p_sck    = w_sck;
            p_sdi    = w_sdi;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Step until result_valid is seen (bounded); result must not move before it
    task automatic wait_valid(input int budget, output int at);
        logic [11:0] r0;
        logic        moved;
        at    = -1;
        r0    = result;
        moved = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (result_valid) begin
                at = cyc;
                break;
            end
            if (result !== r0) moved = 1'b1;
        end
        check("result_stable", 32'(moved), 32'd0);
    endtask

    int at;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_convst", 32'(adc_convst), 32'd0);
        check("rst_sck", 32'(adc_sck), 32'd0);
        check("rst_sdi", 32'(adc_sdi), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_result_chan", 32'(result_chan), 32'd0);
        check("rst_valid", 32'(result_valid), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // First result and cadence
        wait_valid(300, at);
        check("first_valid_at", 32'(at), 32'd263);
        check("first_result", 32'(result), 32'hA5C);
        check("first_chan", 32'(result_chan), 32'd0);
        wait_valid(200, at);
        check("second_valid_at", 32'(at), 32'd394);
        check("second_result", 32'(result), 32'hA5C);

        // Channel pipeline
        chan = 3'd3;
        mode = 1;
        wait_valid(200, at);
        check("f4_at", 32'(at), 32'd525);
        check("f4_result", 32'(result), 32'hA5C);
        wait_valid(200, at);
        check("f5_at", 32'(at), 32'd656);
        check("f5_result", 32'(result), 32'h100);
        check("f5_chan", 32'(result_chan), 32'd0);
        check("f5_sdi_word", 32'(frame_cfg), 32'b110110);
        wait_valid(200, at);
        check("f6_result", 32'(result), 32'h103);
        check("f6_chan", 32'(result_chan), 32'd3);

        // Channel change in the middle of a frame
        chan = 3'd1;
        wait_valid(200, at);
        check("f7_at", 32'(at), 32'd918);
        repeat (90) @(posedge clk);
        #1;
        chan = 3'd6;
        wait_valid(200, at);
        check("f8_sdi_word", 32'(frame_cfg), 32'b110010);
        check("f8_result", 32'(result), 32'h103);
        wait_valid(200, at);
        check("f9_sdi_word", 32'(frame_cfg), 32'b101110);
        check("f9_result", 32'(result), 32'h101);
        check("f9_chan", 32'(result_chan), 32'd1);
        wait_valid(200, at);
        check("f10_at", 32'(at), 32'd1311);
        check("f10_result", 32'(result), 32'h106);
        check("f10_chan", 32'(result_chan), 32'd6);

        // Extreme data words
        mode       = 0;
        const_word = 12'hFFF;
        wait_valid(200, at);
        check("f11_result", 32'(result), 32'h106);
        const_word = 12'h000;
        wait_valid(200, at);
        check("all_ones", 32'(result), 32'hFFF);
        const_word = 12'h801;
        wait_valid(200, at);
        check("all_zeros", 32'(result), 32'h000);
        wait_valid(200, at);
        check("msb_lsb", 32'(result), 32'h801);
        check("f14_at", 32'(at), 32'd1835);

        // Reset during the high phase of bit 5
        repeat (104) @(posedge clk);
        #1;
        check("pre_rst_sck_high", 32'(adc_sck), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_sck", 32'(adc_sck), 32'd0);
        check("mid_rst_convst", 32'(adc_convst), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        reset = 1'b0;
        wait_valid(300, at);
        check("post_rst_valid_at", 32'(at), 32'd263);
        check("post_rst_result", 32'(result), 32'h801);
        check("post_rst_chan", 32'(result_chan), 32'd6);

        // Waveform of the second instance
        check("w_frames_seen", 32'(w_frames >= 3), 32'd1);
        check("w_sck_rises", 32'(w_bad_rises), 32'd0);
        check("w_frame_len", 32'(w_bad_len), 32'd0);
        check("w_sck_phases", 32'(w_bad_phase), 32'd0);
        check("w_convst_width", 32'(w_bad_convst), 32'd0);
        check("w_sck_outside_shift", 32'(w_overlap), 32'd0);
        check("w_result", 32'(w_result), 32'd0);
        check("w_result_chan", 32'(w_result_chan), 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
